// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the picorv32 native memory bus.
// Grants are held until completion; a watchdog force-completes hung transactions.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        m0_mem_valid,
    input  logic [31:0] m0_mem_addr,
    input  logic [31:0] m0_mem_wdata,
    input  logic [3:0]  m0_mem_wstrb,
    output logic        m0_mem_ready,
    output logic [31:0] m0_mem_rdata,
    input  logic        m1_mem_valid,
    input  logic [31:0] m1_mem_addr,
    input  logic [31:0] m1_mem_wdata,
    input  logic [3:0]  m1_mem_wstrb,
    output logic        m1_mem_ready,
    output logic [31:0] m1_mem_rdata,
    output logic        s_mem_valid,
    output logic [31:0] s_mem_addr,
    output logic [31:0] s_mem_wdata,
    output logic [3:0]  s_mem_wstrb,
    input  logic        s_mem_ready,
    input  logic [31:0] s_mem_rdata,
    output logic        grant,
    output logic        busy,
    output logic        timeout_irq,
    output logic [31:0] timeout_addr
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned CW = 16;
    localparam bit          WDOG_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0] WDOG_LAST = WDOG_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
    } bus_req_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic          grant_nxt;
    logic          last_grant, last_grant_nxt;
    logic [CW-1:0] wd_cnt, wd_cnt_nxt;
    logic [AW-1:0] timeout_addr_nxt;

    bus_req_t      m0_req, m1_req, gnt_req, s_req;
    logic          gnt_valid;
    logic          wd_expire;
    logic          done;
    logic [DW-1:0] done_rdata;

    assign m0_req    = {m0_mem_addr, m0_mem_wdata, m0_mem_wstrb};
    assign m1_req    = {m1_mem_addr, m1_mem_wdata, m1_mem_wstrb};
    assign gnt_req   = grant ? m1_req : m0_req;
    assign gnt_valid = grant ? m1_mem_valid : m0_mem_valid;
    assign wd_expire = WDOG_EN && (wd_cnt == WDOG_LAST);

    assign s_mem_addr  = s_req.addr;
    assign s_mem_wdata = s_req.wdata;
    assign s_mem_wstrb = s_req.wstrb;
    assign busy        = (state == BUSY);

    // State and bookkeeping registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            grant        <= 1'b0;
            last_grant   <= 1'b1;
            wd_cnt       <= '0;
            timeout_addr <= '0;
        end else begin
            state        <= state_nxt;
            grant        <= grant_nxt;
            last_grant   <= last_grant_nxt;
            wd_cnt       <= wd_cnt_nxt;
            timeout_addr <= timeout_addr_nxt;
        end
    end

    // Arbitration, transaction tracking and watchdog
    always_comb begin
        state_nxt        = state;
        grant_nxt        = grant;
        last_grant_nxt   = last_grant;
        wd_cnt_nxt       = wd_cnt;
        timeout_addr_nxt = timeout_addr;
        s_mem_valid      = 1'b0;
        s_req            = '0;
        timeout_irq      = 1'b0;
        done             = 1'b0;
        done_rdata       = s_mem_rdata;

        case (state)
            IDLE: begin
                if (m0_mem_valid || m1_mem_valid) begin
                    state_nxt  = BUSY;
                    wd_cnt_nxt = '0;
                    // On a tie the master that was not served last wins
                    grant_nxt  = (m0_mem_valid && m1_mem_valid) ? ~last_grant : m1_mem_valid;
                end
            end
            BUSY: begin
                s_req = gnt_req;
                if (!gnt_valid) begin
                    // Master withdrew its request: drop it silently
                    state_nxt = IDLE;
                end else if (s_mem_ready) begin
                    s_mem_valid    = 1'b1;
                    done           = 1'b1;
                    last_grant_nxt = grant;
                    state_nxt      = IDLE;
                end else if (wd_expire) begin
                    done             = 1'b1;
                    done_rdata       = TIMEOUT_RDATA;
                    timeout_irq      = 1'b1;
                    timeout_addr_nxt = gnt_req.addr;
                    last_grant_nxt   = grant;
                    state_nxt        = IDLE;
                end else begin
                    s_mem_valid = 1'b1;
                    wd_cnt_nxt  = wd_cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Completion strobe and read data steering
    always_comb begin
        m0_mem_ready = done && !grant;
        m1_mem_ready = done && grant;
        m0_mem_rdata = s_mem_rdata;
        m1_mem_rdata = s_mem_rdata;
        if (done && !grant) begin
            m0_mem_rdata = done_rdata;
        end
        if (done && grant) begin
            m1_mem_rdata = done_rdata;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_mem_bus_arbiter;

    localparam int unsigned TO       = 8;
    localparam logic [31:0] TO_RDATA = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  mv;
    logic [31:0] ma  [2];
    logic [31:0] mwd [2];
    logic [3:0]  mws [2];
    logic        m0_mem_ready, m1_mem_ready;
    logic [31:0] m0_mem_rdata, m1_mem_rdata;
    logic        s_mem_valid;
    logic [31:0] s_mem_addr, s_mem_wdata;
    logic [3:0]  s_mem_wstrb;
    logic        s_rdy;
    logic [31:0] s_rd;
    logic        grant, busy, timeout_irq;
    logic [31:0] timeout_addr;
    logic [1:0]  r_seen;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .TIMEOUT_CYCLES(TO),
        .TIMEOUT_RDATA (TO_RDATA)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .m0_mem_valid(mv[0]),
        .m0_mem_addr (ma[0]),
        .m0_mem_wdata(mwd[0]),
        .m0_mem_wstrb(mws[0]),
        .m0_mem_ready(m0_mem_ready),
        .m0_mem_rdata(m0_mem_rdata),
        .m1_mem_valid(mv[1]),
        .m1_mem_addr (ma[1]),
        .m1_mem_wdata(mwd[1]),
        .m1_mem_wstrb(mws[1]),
        .m1_mem_ready(m1_mem_ready),
        .m1_mem_rdata(m1_mem_rdata),
        .s_mem_valid (s_mem_valid),
        .s_mem_addr  (s_mem_addr),
        .s_mem_wdata (s_mem_wdata),
        .s_mem_wstrb (s_mem_wstrb),
        .s_mem_ready (s_rdy),
        .s_mem_rdata (s_rd),
        .grant       (grant),
        .busy        (busy),
        .timeout_irq (timeout_irq),
        .timeout_addr(timeout_addr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    // Ready strobes as the masters see them, used to retire their requests
    always @(negedge clk) begin
        r_seen[0] = m0_mem_ready;
        r_seen[1] = m1_mem_ready;
    end

    // Transaction-level model: who owns the bus, how long it has waited, who was served last
    bit          m_busy, m_own, m_last;
    int          m_age;
    logic [31:0] m_taddr;

    always @(negedge clk) begin
        logic [1:0]  e_rdy;
        logic        e_sv, e_irq;
        logic [31:0] e_addr, e_wd, e_rd;
        logic [3:0]  e_ws;
        bit          n_busy, n_own, n_last;
        int          n_age;
        logic [31:0] n_taddr;

        if (!rstn) begin
            m_busy = 0; m_own = 0; m_last = 1; m_age = 0; m_taddr = '0;
        end
        e_rdy = '0; e_sv = 0; e_irq = 0; e_addr = '0; e_wd = '0; e_ws = '0; e_rd = s_rd;
        n_busy = m_busy; n_own = m_own; n_last = m_last; n_age = m_age; n_taddr = m_taddr;

        if (!m_busy) begin
            if (rstn && mv != 2'b00) begin
                n_busy = 1;
                n_age  = 0;
                n_own  = (mv == 2'b11) ? ~m_last : mv[1];
            end
        end else begin
            e_addr = ma[m_own]; e_wd = mwd[m_own]; e_ws = mws[m_own];
            if (!mv[m_own]) begin
                n_busy = 0;
            end else if (s_rdy) begin
                e_sv = 1; e_rdy[m_own] = 1; n_busy = 0; n_last = m_own;
            end else if (m_age == int'(TO) - 1) begin
                e_rdy[m_own] = 1; e_rd = TO_RDATA; e_irq = 1;
                n_taddr = ma[m_own]; n_busy = 0; n_last = m_own;
            end else begin
                e_sv = 1; n_age = m_age + 1;
            end
        end

        chk("grant", 32'(grant), 32'(m_own));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("timeout_addr", timeout_addr, m_taddr);
        chk("s_mem_valid", 32'(s_mem_valid), 32'(e_sv));
        chk("s_mem_addr", s_mem_addr, e_addr);
        chk("s_mem_wdata", s_mem_wdata, e_wd);
        chk("s_mem_wstrb", 32'(s_mem_wstrb), 32'(e_ws));
        chk("timeout_irq", 32'(timeout_irq), 32'(e_irq));
        chk("m0_mem_ready", 32'(m0_mem_ready), 32'(e_rdy[0]));
        chk("m1_mem_ready", 32'(m1_mem_ready), 32'(e_rdy[1]));
        if (e_rdy[0]) chk("m0_mem_rdata", m0_mem_rdata, e_rd);
        if (e_rdy[1]) chk("m1_mem_rdata", m1_mem_rdata, e_rd);

        m_busy = n_busy; m_own = n_own; m_last = n_last; m_age = n_age; m_taddr = n_taddr;
    end

    initial begin
        int p;
        rstn = 1'b0; mv = '0; s_rdy = 1'b0; s_rd = '0;
        for (int i = 0; i < 2; i++) begin
            ma[i] = '0; mwd[i] = '0; mws[i] = '0;
        end
        repeat (2) @(posedge clk);
        to_neg();
        chk("rst grant", 32'(grant), 32'h0);
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst s_valid", 32'(s_mem_valid), 32'h0);
        step(); rstn = 1'b1;

        // m0 read, slave answers in the second BUSY cycle
        step(); mv = 2'b01; ma[0] = 32'h0000_0010; mws[0] = 4'h0;
        to_neg(); chk("t1 idle s_valid", 32'(s_mem_valid), 32'h0);
        step(); to_neg();
        chk("t1 s_valid", 32'(s_mem_valid), 32'h1);
        chk("t1 s_addr", s_mem_addr, 32'h0000_0010);
        step(); s_rdy = 1'b1; s_rd = 32'h1234_5678;
        to_neg();
        chk("t1 m0_ready", 32'(m0_mem_ready), 32'h1);
        chk("t1 m0_rdata", m0_mem_rdata, 32'h1234_5678);
        chk("t1 m1_ready", 32'(m1_mem_ready), 32'h0);
        step(); mv = 2'b00; s_rdy = 1'b0;
        to_neg();
        chk("t1 ready width", 32'(m0_mem_ready), 32'h0);
        chk("t1 idle", 32'(busy), 32'h0);

        // m1 write contends with m0; m0 was served last so m1 goes first
        step(); mv = 2'b11;
        ma[1] = 32'h2800_0004; mwd[1] = 32'hA5A5_A5A5; mws[1] = 4'hF;
        ma[0] = 32'h0000_0100; mwd[0] = 32'h0; mws[0] = 4'h0;
        to_neg();
        step(); to_neg();
        chk("t3 grant", 32'(grant), 32'h1);
        chk("t3 s_addr", s_mem_addr, 32'h2800_0004);
        chk("t3 s_wdata", s_mem_wdata, 32'hA5A5_A5A5);
        chk("t3 s_wstrb", 32'(s_mem_wstrb), 32'hF);
        step(); to_neg();
        chk("t3 s_addr hold", s_mem_addr, 32'h2800_0004);
        step(); s_rdy = 1'b1; to_neg();
        chk("t3 m1_ready", 32'(m1_mem_ready), 32'h1);
        chk("t3 m0_ready", 32'(m0_mem_ready), 32'h0);
        step(); mv[1] = 1'b0; s_rdy = 1'b0; to_neg();
        chk("t3 gap", 32'(busy), 32'h0);
        step(); to_neg();
        chk("t3 m0 grant", 32'(grant), 32'h0);
        chk("t3 m0 addr", s_mem_addr, 32'h0000_0100);
        step(); s_rdy = 1'b1; to_neg();
        chk("t3 m0 served", 32'(m0_mem_ready), 32'h1);
        step(); mv = 2'b00; s_rdy = 1'b0;

        // Reset asserted in the middle of an m1 transaction
        to_neg();
        step(); mv = 2'b10; ma[1] = 32'h0000_0050; to_neg();
        step(); to_neg();
        step(); rstn = 1'b0; #1;
        chk("t6 s_valid", 32'(s_mem_valid), 32'h0);
        chk("t6 m1_ready", 32'(m1_mem_ready), 32'h0);
        chk("t6 busy", 32'(busy), 32'h0);
        chk("t6 grant", 32'(grant), 32'h0);
        to_neg();

        // Both masters request continuously; first tie after reset goes to m0
        step(); rstn = 1'b1; mv = 2'b11; s_rdy = 1'b1;
        ma[0] = 32'h0000_0040; ma[1] = 32'h0000_0044;
        for (int k = 0; k < 4; k++) begin
            to_neg();
            chk("t2 gap", 32'(busy), 32'h0);
            step(); to_neg();
            chk("t2 grant", 32'(grant), 32'(k % 2));
            chk("t2 m0_ready", 32'(m0_mem_ready), 32'((k % 2) == 0));
            chk("t2 m1_ready", 32'(m1_mem_ready), 32'((k % 2) == 1));
            step();
        end
        mv = 2'b00; s_rdy = 1'b0;

        // Watchdog expiry with a silent slave
        step(); mv = 2'b01; ma[0] = 32'h2000_0008; to_neg();
        for (int i = 0; i < 7; i++) begin
            step(); to_neg();
            chk("t4 waiting", 32'(m0_mem_ready), 32'h0);
        end
        step(); to_neg();
        chk("t4 m0_ready", 32'(m0_mem_ready), 32'h1);
        chk("t4 rdata", m0_mem_rdata, 32'hDEAD_BEEF);
        chk("t4 irq", 32'(timeout_irq), 32'h1);
        chk("t4 s_valid", 32'(s_mem_valid), 32'h0);
        step(); mv = 2'b00; to_neg();
        chk("t4 irq pulse", 32'(timeout_irq), 32'h0);
        chk("t4 taddr", timeout_addr, 32'h2000_0008);

        // Slave answers on the expiry cycle: normal completion wins
        step(); mv = 2'b01; ma[0] = 32'h3000_000C; to_neg();
        for (int i = 0; i < 7; i++) begin
            step(); to_neg();
        end
        step(); s_rdy = 1'b1; s_rd = 32'h0000_0055; to_neg();
        chk("t5 m0_ready", 32'(m0_mem_ready), 32'h1);
        chk("t5 rdata", m0_mem_rdata, 32'h0000_0055);
        chk("t5 no irq", 32'(timeout_irq), 32'h0);
        step(); mv = 2'b00; s_rdy = 1'b0; to_neg();
        chk("t5 taddr", timeout_addr, 32'h2000_0008);

        // Random traffic with varying slave responsiveness
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            p = (cyc < 1000) ? 60 : (cyc < 2000) ? 15 : (cyc < 2500) ? 0 : 40;
            s_rdy = ($urandom_range(0, 99) < p);
            s_rd  = $urandom();
            for (int i = 0; i < 2; i++) begin
                if (!mv[i] || r_seen[i]) begin
                    mv[i]  = ($urandom_range(0, 99) < 50);
                    ma[i]  = $urandom();
                    mwd[i] = $urandom();
                    mws[i] = 4'($urandom());
                end else if ($urandom_range(0, 299) == 0) begin
                    mv[i] = 1'b0;
                end
            end
        end
        step(); mv = 2'b00; s_rdy = 1'b0;
        repeat (3) step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
